// File: rtl/lmsm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lmsm_sequencer_pkg
// Brief    : Shared types and constants for the LM/SM register sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lmsm_sequencer_pkg;

  localparam int DATA_W = 16;   // register / memory data width
  localparam int ADDR_W = 16;   // memory address width
  localparam int NREG   = 8;    // registers in the file
  localparam int IDX_W  = 3;    // register index width

  localparam logic MODE_SM = 1'b0;  // registers -> memory
  localparam logic MODE_LM = 1'b1;  // memory -> registers

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lmsm_sequencer_lowest_set_8.sv
`default_nettype none
// ============================================================================
// Module   : lowest_set_8
// Brief    : 8-bit priority encoder; index of the lowest set bit plus a
//            flag for an all-zero vector. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module lowest_set_8
  import lmsm_sequencer_pkg::*;
(
  input  logic [NREG-1:0]  vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             none_o
);

  // Walk from the top down so the lowest set bit is the last, winning, assignment.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o  = IDX_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lmsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lmsm_sequencer
// Brief    : Load-Multiple / Store-Multiple sequencer. Walks a register mask
//            lowest index first, issuing one memory transaction per selected
//            register and driving the register file read/write ports.
// Revision : 1.0 - initial release
// ============================================================================
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [NREG-1:0]   reg_mask_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [IDX_W-1:0]  rf_read_add_o,
  input  logic [DATA_W-1:0] rf_read_data_i,
  output logic              rf_write_o,
  output logic [IDX_W-1:0]  rf_write_select_o,
  output logic [DATA_W-1:0] rf_write_data_o
);

  state_e            state_q, state_d;
  logic              mode_q;
  logic [NREG-1:0]   mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [IDX_W-1:0]  w_scan_idx;
  logic              w_mask_empty;

  // Next register to service is always the lowest bit still pending.
  lowest_set_8 u_lowest (
    .vec_i  (mask_q),
    .idx_o  (w_scan_idx),
    .none_o (w_mask_empty)
  );

  // The register file read port follows the pending mask directly.
  assign rf_read_add_o     = w_scan_idx;
  assign mem_addr_o        = mem_addr_q;
  assign mem_we_o          = mem_we_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign rf_write_select_o = idx_q;
  assign rf_write_data_o   = rf_wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i)      state_d = ST_SCAN;
      ST_SCAN: state_d = w_mask_empty ? ST_DONE : ST_MEM;
      ST_MEM:  if (mem_ack_i)    state_d = (mode_q == MODE_LM) ? ST_WB : ST_SCAN;
      ST_WB:   state_d = ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the current state only.
  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    mem_req_o  = 1'b0;
    rf_write_o = 1'b1;
    case (state_q)
      ST_SCAN: busy_o = 1'b1;
      ST_MEM:  begin busy_o = 1'b1; mem_req_o  = 1'b1; end
      ST_WB:   begin busy_o = 1'b1; rf_write_o = 1'b0; end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, per-beat transaction registers and mask/address walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_SM;
      mask_q      <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rf_wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q <= mode_i;
            mask_q <= reg_mask_i;
            addr_q <= base_addr_i;
          end
        end
        ST_SCAN: begin
          if (!w_mask_empty) begin
            idx_q      <= w_scan_idx;
            mem_addr_q <= addr_q;
            mem_we_q   <= ~mode_q;
            // Store data is captured here so it stays stable however long the ack takes.
            if (mode_q == MODE_SM) mem_wdata_q <= rf_read_data_i;
          end
        end
        ST_MEM: begin
          if (mem_ack_i) begin
            if (mode_q == MODE_SM) begin
              mask_q[idx_q] <= 1'b0;
              addr_q        <= addr_q + ADDR_W'(1);
            end else begin
              rf_wdata_q <= mem_rdata_i;
            end
          end
        end
        ST_WB: begin
          mask_q[idx_q] <= 1'b0;
          addr_q        <= addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lmsm_sequencer
// Brief    : Directed self-checking bench for lmsm_sequencer. A small memory
//            responder with programmable ack delay and a register-file model
//            log every handshake and write strobe for later comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [7:0]  reg_mask_i = 8'h00;
  logic [15:0] base_addr_i = 16'h0000;
  logic        busy_o, done_o, mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_rdata_i = 16'h0000;
  logic [2:0]  rf_read_add_o;
  logic [15:0] rf_read_data_i;
  logic        rf_write_o;
  logic [2:0]  rf_write_select_o;
  logic [15:0] rf_write_data_o;

  int checks = 0;
  int errors = 0;

  lmsm_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .mode_i            (mode_i),
    .reg_mask_i        (reg_mask_i),
    .base_addr_i       (base_addr_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_ack_i         (mem_ack_i),
    .mem_rdata_i       (mem_rdata_i),
    .rf_read_add_o     (rf_read_add_o),
    .rf_read_data_i    (rf_read_data_i),
    .rf_write_o        (rf_write_o),
    .rf_write_select_o (rf_write_select_o),
    .rf_write_data_o   (rf_write_data_o)
  );

  always #5 clk = ~clk;

  // Combinational register-file read port.
  logic [15:0] rf_model [0:7];
  assign rf_read_data_i = rf_model[rf_read_add_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder and logger state.
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          in_req    = 1'b0;
  logic [15:0] snap_addr, snap_wdata;
  logic        snap_we;
  logic [15:0] ld_data [0:3];
  int          ld_ptr = 0;
  logic        tx_we    [0:15];
  logic [15:0] tx_addr  [0:15];
  logic [15:0] tx_wdata [0:15];
  int          tx_n = 0;
  logic [2:0]  wr_sel   [0:15];
  logic [15:0] wr_data  [0:15];
  int          wr_n = 0;

  // Everything is observed on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (!rf_write_o) begin
      if (wr_n < 16) begin
        wr_sel[wr_n]  = rf_write_select_o;
        wr_data[wr_n] = rf_write_data_o;
      end
      wr_n++;
    end
    if (mem_req_o) begin
      if (!in_req) begin
        snap_addr  = mem_addr_o;
        snap_we    = mem_we_o;
        snap_wdata = mem_wdata_o;
        in_req     = 1'b1;
        wait_cnt   = 0;
      end else begin
        check("hold_addr", mem_addr_o, snap_addr);
        check("hold_we", mem_we_o, snap_we);
        check("hold_wdata", mem_wdata_o, snap_wdata);
      end
      if (wait_cnt == ack_delay) begin
        if (tx_n < 16) begin
          tx_we[tx_n]    = mem_we_o;
          tx_addr[tx_n]  = mem_addr_o;
          tx_wdata[tx_n] = mem_wdata_o;
        end
        tx_n++;
        if (!mem_we_o) begin
          mem_rdata_i = ld_data[ld_ptr % 4];
          ld_ptr++;
        end
        mem_ack_i = 1'b1;
        in_req    = 1'b0;
      end else begin
        wait_cnt++;
      end
    end else begin
      in_req = 1'b0;
    end
  end

  task automatic clear_logs();
    tx_n = 0; wr_n = 0; ld_ptr = 0;
  endtask

  // Pulse start for one cycle, then scramble the operands to show they were latched.
  task automatic start_op(input logic m, input logic [7:0] mk, input logic [15:0] b);
    @(negedge clk);
    mode_i = m; reg_mask_i = mk; base_addr_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; mode_i = ~m; reg_mask_i = 8'hFF; base_addr_i = 16'hDEAD;
    check("busy_after_start", busy_o, 1'b1);
  endtask

  // lat = k means done is seen in the k-th clock period after the accepting edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done_o, 1'b1);
    check("busy_in_done", busy_o, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

  int lat;

  initial begin
    for (int i = 0; i < 8; i++) rf_model[i] = 16'h0F00 + 16'(i);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state.
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_we", mem_we_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 16'h0000);
    check("rst_mem_wdata", mem_wdata_o, 16'h0000);
    check("rst_rf_read_add", rf_read_add_o, 3'd0);
    check("rst_rf_write", rf_write_o, 1'b1);
    check("rst_rf_sel", rf_write_select_o, 3'd0);
    check("rst_rf_wdata", rf_write_data_o, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // SM of r0, r2, r7 from 0x0040 with zero-wait memory.
    rf_model[0] = 16'h1111; rf_model[2] = 16'h2222; rf_model[7] = 16'h7777;
    ack_delay = 0;
    clear_logs();
    start_op(1'b0, 8'b1000_0101, 16'h0040);
    wait_done(lat);
    check("sm_latency", lat, 8);
    check("sm_tx_count", tx_n, 3);
    check("sm_rf_writes", wr_n, 0);
    check("sm0_we", tx_we[0], 1'b1);
    check("sm0_addr", tx_addr[0], 16'h0040);
    check("sm0_data", tx_wdata[0], 16'h1111);
    check("sm1_addr", tx_addr[1], 16'h0041);
    check("sm1_data", tx_wdata[1], 16'h2222);
    check("sm2_addr", tx_addr[2], 16'h0042);
    check("sm2_data", tx_wdata[2], 16'h7777);

    // LM of r1, r6 from 0x0100 with zero-wait memory.
    ld_data[0] = 16'hABCD; ld_data[1] = 16'h1234;
    clear_logs();
    start_op(1'b1, 8'b0100_0010, 16'h0100);
    wait_done(lat);
    check("lm_latency", lat, 8);
    check("lm_tx_count", tx_n, 2);
    check("lm0_we", tx_we[0], 1'b0);
    check("lm0_addr", tx_addr[0], 16'h0100);
    check("lm1_addr", tx_addr[1], 16'h0101);
    check("lm_rf_writes", wr_n, 2);
    check("lm0_sel", wr_sel[0], 3'd1);
    check("lm0_data", wr_data[0], 16'hABCD);
    check("lm1_sel", wr_sel[1], 3'd6);
    check("lm1_data", wr_data[1], 16'h1234);

    // LM of r3, r5 with a three-cycle ack delay on every beat.
    ld_data[0] = 16'h5A5A; ld_data[1] = 16'hC3C3;
    ack_delay = 3;
    clear_logs();
    start_op(1'b1, 8'b0010_1000, 16'h2000);
    wait_done(lat);
    ack_delay = 0;
    check("lmw_latency", lat, 14);
    check("lmw_tx_count", tx_n, 2);
    check("lmw0_addr", tx_addr[0], 16'h2000);
    check("lmw1_addr", tx_addr[1], 16'h2001);
    check("lmw_rf_writes", wr_n, 2);
    check("lmw0_sel", wr_sel[0], 3'd3);
    check("lmw0_data", wr_data[0], 16'h5A5A);
    check("lmw1_sel", wr_sel[1], 3'd5);
    check("lmw1_data", wr_data[1], 16'hC3C3);

    // Empty mask; start is held high through the busy and DONE cycles.
    clear_logs();
    @(negedge clk);
    mode_i = 1'b0; reg_mask_i = 8'h00; base_addr_i = 16'h0055; start_i = 1'b1;
    @(negedge clk);
    reg_mask_i = 8'hFF;
    check("m0_busy", busy_o, 1'b1);
    lat = 1;
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("m0_done_seen", done_o, 1'b1);
    check("m0_latency", lat, 2);
    @(negedge clk);
    start_i = 1'b0;
    check("m0_done_one_cycle", done_o, 1'b0);
    check("m0_idle_busy", busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check("m0_still_idle", busy_o, 1'b0);
    check("m0_tx_count", tx_n, 0);
    check("m0_rf_writes", wr_n, 0);

    // SM across the top of the address space.
    rf_model[0] = 16'hA0A0; rf_model[1] = 16'hB1B1;
    clear_logs();
    start_op(1'b0, 8'b0000_0011, 16'hFFFF);
    wait_done(lat);
    check("wrap_latency", lat, 6);
    check("wrap_tx_count", tx_n, 2);
    check("wrap0_addr", tx_addr[0], 16'hFFFF);
    check("wrap0_data", tx_wdata[0], 16'hA0A0);
    check("wrap1_addr", tx_addr[1], 16'h0000);
    check("wrap1_data", tx_wdata[1], 16'hB1B1);

    // Asynchronous reset while the first LM write strobe is active.
    ld_data[0] = 16'h9999; ld_data[1] = 16'h8888;
    clear_logs();
    start_op(1'b1, 8'h81, 16'h0010);
    lat = 1;
    while (rf_write_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("wb_reached", rf_write_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rf_write", rf_write_o, 1'b1);
    check("arst_busy", busy_o, 1'b0);
    check("arst_mem_req", mem_req_o, 1'b0);
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_req", tx_n, 0);
    check("arst_no_write", wr_n, 0);
    check("arst_idle", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
